// File: rtl/alu_op_responder_if.sv
// Request/response bundle for alu_op_responder.
//   master: op-issuing controller side; drives requests and consumes responses
//   slave : responder side; accepts requests and presents queued results
//   req_valid/req_ready/req_op/req_a/req_b : request channel (op 00=AND 01=OR 10=ADD 11=SUB)
//   rsp_valid/rsp_ready/rsp_result/rsp_carry: response channel, head of FIFO
//   rsp_count                               : entries currently queued
interface alu_op_responder_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic [CntW-1:0]  rsp_count;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_count
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_count
  );
endinterface

// File: rtl/alu_op_responder.sv
// ALU request/response server: computes AND/OR/ADD/SUB on each accepted request in one
// cycle and queues {carry,result} in an in-order FIFO drained by the consumer.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, flushes the FIFO
//   bus : alu_op_responder_if.slave (request channel in, response channel out)
module alu_op_responder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  alu_op_responder_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEPTH);

  // Each entry stores {carry, result}.
  logic [WIDTH:0]   r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;

  logic             w_req_ready;
  logic             w_rsp_valid;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH:0]   w_entry;
  logic [CntW-1:0]  w_count_next;

  // Ready depends only on registered occupancy, so a full FIFO refuses a push even
  // when a pop happens in the same cycle.
  assign w_req_ready = (r_count < CntMax);
  assign w_rsp_valid = (r_count != '0);
  assign w_push      = bus.req_valid & w_req_ready;
  assign w_pop       = w_rsp_valid & bus.rsp_ready;

  always_comb begin
    w_entry = '0;
    case (bus.req_op)
      2'b00: w_entry = {1'b0, bus.req_a & bus.req_b};
      2'b01: w_entry = {1'b0, bus.req_a | bus.req_b};
      2'b10: w_entry = {1'b0, bus.req_a} + {1'b0, bus.req_b};
      // Bit WIDTH of the widened difference is the borrow, i.e. (a < b) unsigned.
      2'b11: w_entry = {1'b0, bus.req_a} - {1'b0, bus.req_b};
      default: w_entry = '0;
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CntOne;
      2'b01:   w_count_next = r_count - CntOne;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + PtrOne;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
      r_count <= w_count_next;
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_result = w_rsp_valid ? r_mem[r_rd_ptr][WIDTH-1:0] : '0;
  assign bus.rsp_carry  = w_rsp_valid ? r_mem[r_rd_ptr][WIDTH]     : 1'b0;
  assign bus.rsp_count  = r_count;
endmodule

// File: tb/tb_alu_op_responder.sv
// Scoreboard bench for alu_op_responder: expected {carry,result} pushed on issue,
// popped and compared by a monitor whenever a response handshake occurs.
module tb_alu_op_responder;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  localparam logic [1:0] OpAnd = 2'b00;
  localparam logic [1:0] OpOr  = 2'b01;
  localparam logic [1:0] OpAdd = 2'b10;
  localparam logic [1:0] OpSub = 2'b11;

  logic clk;
  logic rst;

  alu_op_responder_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  alu_op_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] sb_q [$];
  logic [8:0] mon_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the head response against the scoreboard on each pop.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got %h, expected no response (t=%0t)",
                 {bus.rsp_carry, bus.rsp_result}, $time);
      end else begin
        mon_exp = sb_q.pop_front();
        check("rsp_data", {23'd0, bus.rsp_carry, bus.rsp_result}, {23'd0, mon_exp});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait until the currently presented request is accepted (bounded).
  task automatic wait_fire(input string name);
    logic rdy;
    logic fired;
    fired = 1'b0;
    for (int c = 0; c < 50; c++) begin
      rdy = bus.req_ready;
      tick();
      if (rdy) begin
        fired = 1'b1;
        break;
      end
    end
    if (!fired) check(name, 32'd0, 32'd1);
  endtask

  task automatic present(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [8:0] exp);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    sb_q.push_back(exp);
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [8:0] exp);
    present(op, a, b, exp);
    wait_fire("issue_timeout");
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_a     = 8'hAA;
    bus.req_b     = 8'h55;
  endtask

  task automatic drain(input string name);
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (sb_q.size() == 0 && !bus.rsp_valid) break;
      tick();
    end
    check(name, 32'(sb_q.size()), 32'd0);
    check({name, "_count"}, 32'(bus.rsp_count), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    idle();
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_result", 32'({bus.rsp_carry, bus.rsp_result}), 32'd0);
    check("rst_count", 32'(bus.rsp_count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 1: single AND, one-cycle latency
    issue(OpAnd, 8'hF0, 8'h3C, 9'h030);
    idle();
    check("t1_valid", 32'(bus.rsp_valid), 32'd1);
    check("t1_count", 32'(bus.rsp_count), 32'd1);
    check("t1_result", 32'({bus.rsp_carry, bus.rsp_result}), 32'h030);
    drain("t1_drain");

    // 2: ADD carry, SUB borrow, OR
    bus.rsp_ready = 1'b1;
    issue(OpAdd, 8'hFF, 8'h02, 9'h101);
    issue(OpSub, 8'h05, 8'h07, 9'h1FE);
    issue(OpOr,  8'h0A, 8'h50, 9'h05A);
    idle();
    drain("t2_drain");

    // 3: fill with consumer stalled, 5th request stalls
    bus.rsp_ready = 1'b0;
    tick();
    issue(OpAdd, 8'h10, 8'h01, 9'h011);
    issue(OpAnd, 8'hFF, 8'h0F, 9'h00F);
    issue(OpOr,  8'h80, 8'h01, 9'h081);
    issue(OpSub, 8'h01, 8'h01, 9'h000);
    present(OpAdd, 8'h80, 8'h80, 9'h100);
    check("t3_full_count", 32'(bus.rsp_count), 32'd4);
    check("t3_full_ready", 32'(bus.req_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t3_stall_count", 32'(bus.rsp_count), 32'd4);
      check("t3_stall_head", 32'({bus.rsp_carry, bus.rsp_result}), 32'h011);
    end
    bus.rsp_ready = 1'b1;
    wait_fire("t3_fifth_timeout");
    idle();
    drain("t3_drain");

    // 4: simultaneous push and pop at count 2
    bus.rsp_ready = 1'b0;
    tick();
    issue(OpAdd, 8'h01, 8'h02, 9'h003);
    issue(OpAdd, 8'h03, 8'h04, 9'h007);
    check("t4_pre_count", 32'(bus.rsp_count), 32'd2);
    bus.rsp_ready = 1'b1;
    issue(OpOr, 8'h30, 8'h03, 9'h033);
    bus.rsp_ready = 1'b0;
    idle();
    check("t4_count", 32'(bus.rsp_count), 32'd2);
    check("t4_head", 32'({bus.rsp_carry, bus.rsp_result}), 32'h007);
    drain("t4_drain");

    // 5: reset mid-cycle with 3 entries queued
    bus.rsp_ready = 1'b0;
    tick();
    issue(OpAdd, 8'h11, 8'h22, 9'h033);
    issue(OpAdd, 8'h44, 8'h55, 9'h099);
    issue(OpAnd, 8'h77, 8'h0F, 9'h007);
    idle();
    check("t5_pre_count", 32'(bus.rsp_count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    sb_q.delete();
    check("t5_valid", 32'(bus.rsp_valid), 32'd0);
    check("t5_count", 32'(bus.rsp_count), 32'd0);
    check("t5_ready", 32'(bus.req_ready), 32'd1);
    check("t5_result", 32'({bus.rsp_carry, bus.rsp_result}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    check("t5_post_valid", 32'(bus.rsp_valid), 32'd0);

    // 6: back-to-back ADDs with consumer always ready
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] a;
      logic [8:0] e;
      a = 8'(i);
      e = 9'(i + 1);
      issue(OpAdd, a, 8'h01, e);
      check("t6_count_le1", 32'(bus.rsp_count <= 3'd1), 32'd1);
    end
    idle();
    drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
